// File: rtl/image_uart_sender.sv
// rtl/image_uart_sender.sv - streams a stored greyscale image from BRAM as 8N1 UART bytes
//
// Reads NUM_PIXELS bytes from the image BRAM read port, pixel 0 first, and
// shifts each one out on tx_out as start bit, 8 data bits LSB first, stop bit.
//
// Ports:
//   clk_in    - system clock, single domain
//   rst_in    - synchronous active-high reset
//   start_in  - one-cycle request to send the whole image (ignored while busy)
//   addr_out  - BRAM read address
//   pixel_in  - BRAM read data, valid READ_LATENCY cycles after the address
//   busy_out  - high while a transfer is in progress
//   done_out  - one-cycle pulse in the cycle after the final stop bit
//   tx_out    - UART line, idles high

module image_uart_sender #(
    parameter int CLOCKS_PER_BAUD = 50,
    parameter int NUM_PIXELS      = 16384,
    parameter int ADDR_WIDTH      = 14,
    parameter int READ_LATENCY    = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    output logic [ADDR_WIDTH-1:0] addr_out,
    input  logic [7:0]            pixel_in,
    output logic                  busy_out,
    output logic                  done_out,
    output logic                  tx_out
);

    localparam int BAUD_W  = (CLOCKS_PER_BAUD > 1) ? $clog2(CLOCKS_PER_BAUD) : 1;
    localparam int FETCH_W = $clog2(READ_LATENCY + 2);

    localparam logic [BAUD_W-1:0]     BAUD_LAST  = BAUD_W'(CLOCKS_PER_BAUD - 1);
    localparam logic [FETCH_W-1:0]    FETCH_LAST = FETCH_W'(READ_LATENCY);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(NUM_PIXELS - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
        STOP
    } state_t;

    state_t              state;
    logic [BAUD_W-1:0]   baud_cnt;
    logic [FETCH_W-1:0]  fetch_cnt;
    logic [2:0]          bit_cnt;
    logic [7:0]          shift_reg;
    logic                baud_last;

    assign baud_last = (baud_cnt == BAUD_LAST);

    // tx_out is registered, so every transition sets the line level that the
    // new state drives from its very first cycle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= IDLE;
            addr_out  <= '0;
            busy_out  <= 1'b0;
            done_out  <= 1'b0;
            tx_out    <= 1'b1;
            baud_cnt  <= '0;
            fetch_cnt <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            done_out <= 1'b0;
            case (state)
                IDLE: begin
                    tx_out <= 1'b1;
                    if (start_in) begin
                        addr_out  <= '0;
                        busy_out  <= 1'b1;
                        fetch_cnt <= '0;
                        baud_cnt  <= '0;
                        state     <= FETCH;
                    end
                end

                // Address is held READ_LATENCY+1 cycles: full BRAM latency
                // plus one margin cycle before the data is captured.
                FETCH: begin
                    tx_out <= 1'b1;
                    if (fetch_cnt == FETCH_LAST) begin
                        shift_reg <= pixel_in;
                        baud_cnt  <= '0;
                        tx_out    <= 1'b0;
                        state     <= START;
                    end else begin
                        fetch_cnt <= fetch_cnt + 1'b1;
                    end
                end

                START: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx_out   <= shift_reg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                // shift_reg[0] is always the bit currently on the line.
                DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            tx_out  <= 1'b1;
                            state   <= STOP;
                        end else begin
                            bit_cnt   <= bit_cnt + 1'b1;
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            tx_out    <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                STOP: begin
                    tx_out <= 1'b1;
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (addr_out == ADDR_LAST) begin
                            addr_out <= '0;
                            busy_out <= 1'b0;
                            done_out <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            addr_out  <= addr_out + ADDR_ONE;
                            fetch_cnt <= '0;
                            state     <= FETCH;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: begin
                    state  <= IDLE;
                    tx_out <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_image_uart_sender.sv
// tb/tb_image_uart_sender.sv - self-checking bench for image_uart_sender

module tb_image_uart_sender;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic [3:0] addr_a, addr_b, addr_c;
    logic [7:0] pix_a, pix_b, pix_c;
    logic       busy_a, busy_b, busy_c;
    logic       done_a, done_b, done_c;
    logic       tx_a, tx_b, tx_c;

    logic [7:0] mem [16];
    logic [7:0] pa1, pb1, pc1;

    int vectors = 0;
    int miscompares = 0;
    int prints = 0;

    always #5 clk = ~clk;

    // Single-pixel image, latency 2
    image_uart_sender #(.CLOCKS_PER_BAUD(4), .NUM_PIXELS(1), .ADDR_WIDTH(4), .READ_LATENCY(2)) dut_a (
        .clk_in(clk), .rst_in(rst), .start_in(start_a), .addr_out(addr_a),
        .pixel_in(pix_a), .busy_out(busy_a), .done_out(done_a), .tx_out(tx_a));

    // 16-pixel image, latency 2
    image_uart_sender #(.CLOCKS_PER_BAUD(4), .NUM_PIXELS(16), .ADDR_WIDTH(4), .READ_LATENCY(2)) dut_b (
        .clk_in(clk), .rst_in(rst), .start_in(start_b), .addr_out(addr_b),
        .pixel_in(pix_b), .busy_out(busy_b), .done_out(done_b), .tx_out(tx_b));

    // 16-pixel image, latency 1
    image_uart_sender #(.CLOCKS_PER_BAUD(4), .NUM_PIXELS(16), .ADDR_WIDTH(4), .READ_LATENCY(1)) dut_c (
        .clk_in(clk), .rst_in(rst), .start_in(start_c), .addr_out(addr_c),
        .pixel_in(pix_c), .busy_out(busy_c), .done_out(done_c), .tx_out(tx_c));

    // BRAM models: registered read pipelines of the given latency
    always @(posedge clk) begin
        pa1   <= mem[addr_a];
        pix_a <= pa1;
        pb1   <= mem[addr_b];
        pix_b <= pb1;
        pc1   <= mem[addr_c];
    end
    assign pix_c = pc1;

    function automatic logic get_tx(input int d);
        case (d)
            0: return tx_a;
            1: return tx_b;
            default: return tx_c;
        endcase
    endfunction

    function automatic logic get_busy(input int d);
        case (d)
            0: return busy_a;
            1: return busy_b;
            default: return busy_c;
        endcase
    endfunction

    function automatic logic get_done(input int d);
        case (d)
            0: return done_a;
            1: return done_b;
            default: return done_c;
        endcase
    endfunction

    function automatic logic [3:0] get_addr(input int d);
        case (d)
            0: return addr_a;
            1: return addr_b;
            default: return addr_c;
        endcase
    endfunction

    task automatic set_start(input int d, input logic v);
        case (d)
            0: start_a = v;
            1: start_b = v;
            default: start_c = v;
        endcase
    endtask

    // Reference line level j cycles after the start edge: each byte occupies
    // rl+1 idle fetch cycles followed by a 10-bit frame of cpb cycles per bit.
    function automatic logic exp_tx(input int j, input int rl, input int cpb);
        int p, byt, off, bi;
        logic [7:0] v;
        p   = rl + 1 + 10 * cpb;
        byt = j / p;
        off = j % p;
        if (off < rl + 1) return 1'b1;
        bi = (off - rl - 1) / cpb;
        if (bi == 0) return 1'b0;
        if (bi == 9) return 1'b1;
        v = mem[byt];
        return v[bi - 1];
    endfunction

    // Called at the sample point just after the start edge (j=0). Checks every
    // cycle of a transfer through the done cycle. stop_at >= 0 returns early
    // at that cycle; b2b requests a new transfer in the done cycle.
    task automatic run_transfer(input int d, input int n, input int rl, input int cpb,
                                input bit noisy, input bit b2b, input int stop_at);
        int p, total;
        logic e_tx, e_busy, e_done;
        logic [3:0] e_addr;
        p     = rl + 1 + 10 * cpb;
        total = n * p;
        for (int j = 0; j <= total; j++) begin
            if (j == stop_at) return;
            e_tx   = (j < total) ? exp_tx(j, rl, cpb) : 1'b1;
            e_busy = (j < total);
            e_done = (j == total);
            e_addr = (j < total) ? 4'(j / p) : 4'd0;
            vectors += 4;
            if (get_tx(d) !== e_tx) begin
                miscompares++;
                if (prints++ < 30) $display("FAIL tx dut%0d j=%0d got %b expected %b", d, j, get_tx(d), e_tx);
            end
            if (get_busy(d) !== e_busy) begin
                miscompares++;
                if (prints++ < 30) $display("FAIL busy dut%0d j=%0d got %b expected %b", d, j, get_busy(d), e_busy);
            end
            if (get_done(d) !== e_done) begin
                miscompares++;
                if (prints++ < 30) $display("FAIL done dut%0d j=%0d got %b expected %b", d, j, get_done(d), e_done);
            end
            if (get_addr(d) !== e_addr) begin
                miscompares++;
                if (prints++ < 30) $display("FAIL addr dut%0d j=%0d got %0d expected %0d", d, j, get_addr(d), e_addr);
            end
            if (j < total) set_start(d, noisy && ($urandom_range(0, 29) == 0));
            else           set_start(d, b2b);
            @(negedge clk);
        end
        set_start(d, 1'b0);
    endtask

    task automatic check_idle(input int d, input int cycles, input string name);
        for (int k = 0; k < cycles; k++) begin
            vectors++;
            if (get_tx(d) !== 1'b1 || get_busy(d) !== 1'b0 || get_done(d) !== 1'b0 || get_addr(d) !== 4'd0) begin
                miscompares++;
                $display("FAIL %s dut%0d got tx=%b busy=%b done=%b addr=%0d expected tx=1 busy=0 done=0 addr=0",
                         name, d, get_tx(d), get_busy(d), get_done(d), get_addr(d));
            end
            @(negedge clk);
        end
    endtask

    task automatic pulse_start(input int d);
        set_start(d, 1'b1);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 3; d++) check_idle(d, 1, "reset");
    endtask

    task automatic test_single_byte;
        mem[0] = 8'hA5;
        check_idle(0, 2, "single_pre");
        pulse_start(0);
        run_transfer(0, 1, 2, 4, 1'b0, 1'b0, -1);
        check_idle(0, 3, "single_post");
    endtask

    task automatic test_image_ordering;
        for (int i = 0; i < 16; i++) mem[i] = 8'(i * 17);
        pulse_start(1);
        run_transfer(1, 16, 2, 4, 1'b0, 1'b0, -1);
        check_idle(1, 3, "order_post");
    endtask

    task automatic test_ignored_start;
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        pulse_start(1);
        run_transfer(1, 16, 2, 4, 1'b1, 1'b0, -1);
        check_idle(1, 3, "ignored_post");
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        pulse_start(1);
        run_transfer(1, 16, 2, 4, 1'b0, 1'b1, -1);
        run_transfer(1, 16, 2, 4, 1'b0, 1'b0, -1);
        check_idle(1, 3, "b2b_post");
    endtask

    task automatic test_reset_mid_byte;
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        pulse_start(1);
        // Second cycle of data bit 3 of pixel 0
        run_transfer(1, 16, 2, 4, 1'b0, 1'b0, 3 + 4 * 4 + 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle(1, 3, "reset_mid");
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        pulse_start(1);
        run_transfer(1, 16, 2, 4, 1'b0, 1'b0, -1);
    endtask

    task automatic test_reset_with_start;
        rst = 1'b1;
        start_b = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start_b = 1'b0;
        check_idle(1, 3, "reset_with_start");
    endtask

    task automatic test_latency;
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        pulse_start(2);
        run_transfer(2, 16, 1, 4, 1'b1, 1'b0, -1);
        check_idle(2, 3, "latency_post");
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'd0;
        @(negedge clk);
        test_reset;
        test_single_byte;
        test_image_ordering;
        test_ignored_start;
        test_back_to_back;
        test_reset_mid_byte;
        test_reset_with_start;
        test_latency;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/image_uart_sender.md
# image_uart_sender

Streams a stored 8-bit greyscale image out of the image BRAM's read port as 8N1 UART bytes, pixel 0 first, one byte per address. It sits between the received-image BRAM (port B) and the board's `uart_txd` pin. It is the reader/transmit counterpart to the UART receive path that fills that BRAM. It contains its own baud generator and serializer, so no separate transmitter is instantiated.

## Interface
Parameters:
- `CLOCKS_PER_BAUD`, default 50: clock cycles per UART bit.
- `NUM_PIXELS`, default 16384: bytes per image (128×128). Must be ≥1.
- `ADDR_WIDTH`, default 14: BRAM address width, with 2^ADDR_WIDTH ≥ NUM_PIXELS.
- `READ_LATENCY`, default 2: BRAM cycles from address to valid data (registered output).

Ports:
- `clk_in`, input, 1: system clock. One clock domain; everything is synchronous to `clk_in`.
- `rst_in`, input, 1: reset, synchronous and active-high.
- `start_in`, input, 1: single-cycle request to send the whole image.
- `addr_out`, output, ADDR_WIDTH: BRAM read address.
- `pixel_in`, input, 8: BRAM read data.
- `busy_out`, output, 1: high while a transfer is in progress.
- `done_out`, output, 1: one-cycle pulse after the last stop bit.
- `tx_out`, output, 1: UART line. Idles high.

## Operation
- States: IDLE, FETCH, START, DATA, STOP.
- Reset values (all outputs registered): `tx_out`=1, `busy_out`=0, `done_out`=0, `addr_out`=0, state IDLE, all counters 0.
- **IDLE:**
  - `start_in`=1 → `addr_out`←0, `busy_out`←1, go to FETCH.
  - `start_in` in any other state is ignored; it is not queued.
- **FETCH:**
  - Hold `addr_out` for READ_LATENCY+1 cycles.
  - On the last FETCH cycle, capture `pixel_in` into an 8-bit shift register, then go to START.
- **START:** `tx_out`=0 for CLOCKS_PER_BAUD cycles.
- **DATA:**
  - 8 bits, LSB first, each held for CLOCKS_PER_BAUD cycles.
  - A bit counter (0–7) selects the bit.
- **STOP:** `tx_out`=1 for CLOCKS_PER_BAUD cycles. At the end of STOP:
  - If `addr_out` ≠ NUM_PIXELS−1: `addr_out`←`addr_out`+1, go to FETCH.
  - Otherwise: go to IDLE, `addr_out`←0, `busy_out`←0, `done_out`←1 for exactly one cycle.
- Address arithmetic is unsigned ADDR_WIDTH bits. `addr_out` never exceeds NUM_PIXELS−1 and never wraps mid-image.
- The baud counter runs 0…CLOCKS_PER_BAUD−1 and is cleared on every state entry.
- `tx_out` is high in IDLE and in FETCH, so there is idle-line time between bytes.
- **Reset mid-transfer:** on the next edge the block returns to reset values, `tx_out`=1 immediately, and no `done_out` pulse is issued. A truncated frame on the line is acceptable.
- **Simultaneous `done_out` and `start_in`:** the block is already in IDLE in the `done_out` cycle, so `start_in` that cycle is accepted and a new transfer begins.
- **`rst_in` and `start_in` together:** reset wins.

## Timing
- `start_in` sampled at edge T:
  - `addr_out`=0 and `busy_out`=1 from cycle T+1.
  - First FETCH spans cycles T+1 … T+1+READ_LATENCY.
  - `tx_out` falls at cycle T+2+READ_LATENCY.
- Byte period is READ_LATENCY+1+10·CLOCKS_PER_BAUD cycles: 503 with defaults.
- Full image takes NUM_PIXELS·(READ_LATENCY+1+10·CLOCKS_PER_BAUD) cycles: 8,241,152 with defaults.
- `done_out` is high in the cycle immediately after the final stop bit's last cycle. `busy_out` falls in that same cycle.
- `pixel_in` is sampled exactly READ_LATENCY+1 cycles after `addr_out` changes, i.e. after a full READ_LATENCY settles plus one margin cycle.

## Test plan
- **Single byte:** NUM_PIXELS=1, CLOCKS_PER_BAUD=4, BRAM model with data 0xA5, pulse `start_in`.
  - `tx_out` sequence 0,1,0,1,0,0,1,0,1,1, each for 4 cycles.
  - `tx_out` falls 4 cycles after `start_in`.
  - `done_out` pulses once, 43 cycles after the `start_in` edge.
- **Full image ordering:** NUM_PIXELS=16, CLOCKS_PER_BAUD=4, memory[i]=i·17 mod 256.
  - A UART monitor decodes 16 bytes 0x00,0x11,…,0xFF in order.
  - `addr_out` steps 0…15, then returns to 0.
  - `busy_out` is high throughout.
- **Ignored start:** pulse `start_in` repeatedly while `busy_out`=1.
  - Byte count stays 16 and the address sequence is unchanged.
- **Back-to-back transfers:** assert `start_in` in the same cycle `done_out`=1.
  - A second full image follows with no missed pixel 0.
  - `done_out` pulses once per image.
- **Reset mid-byte:** assert `rst_in` during DATA bit 3.
  - The next cycle shows `tx_out`=1, `busy_out`=0, `addr_out`=0, `done_out`=0.
  - A subsequent `start_in` restarts from pixel 0.
- **Latency parameter:** READ_LATENCY=1 with a 1-cycle BRAM model.
  - Bytes decode correctly.
  - Byte period is 2+10·CLOCKS_PER_BAUD cycles.
